// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file family.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  typedef logic [DEF_DATA_W-1:0]           reg_data_t;
  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_index_t;

  localparam reg_index_t REG_ZERO     = '0;
  localparam reg_data_t  REG_ZERO_VAL = '0;
  localparam reg_data_t  REG_ONE_VAL  = reg_data_t'(1);

endpackage

// File: rtl/regfile_read_port_m.sv
// One registered read port with priority write-through bypass and busy lookup.
module regfile_read_port_m
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IDX_W    = 5,
  parameter int NUM_WR   = 2,
  parameter int HAS_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         rd_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*IDX_W-1:0]  wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_busy,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_busy
);

  logic [DATA_W-1:0] data_d;
  logic              busy_d;
  logic              hit;

  // Later ports override earlier ones, so the highest match wins.
  always_comb begin
    data_d = mem_data;
    hit    = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && wr_addr[w*IDX_W +: IDX_W] == rd_addr) begin
        data_d = wr_data[w*DATA_W +: DATA_W];
        hit    = 1'b1;
      end
    end
    busy_d = mem_busy & ~hit;
    if (HAS_ZERO != 0 && rd_addr == IDX_W'(REG_ZERO)) begin
      data_d = DATA_W'(REG_ZERO_VAL);
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else if (rd_en) begin
      rd_data <= data_d;
      rd_busy <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_mp_m.sv
// Multi-port register file with per-register pending-writeback scoreboard.
module regfile_mp_m
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = 4,
  parameter  int NUM_WR   = 2,
  parameter  int HAS_ZERO = 1,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*IDX_W-1:0]  rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*IDX_W-1:0]  wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        busy_set_en,
  input  logic [NUM_WR*IDX_W-1:0]  busy_set_addr,
  output logic                     wr_conflict
);

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_WR-1:0]   wr_ok;
  logic                conflict_d;

  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wr_ok[w] = wr_en[w] &&
        !(HAS_ZERO != 0 &&
          wr_addr[w*IDX_W +: IDX_W] == IDX_W'(REG_ZERO));
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (wr_ok[a] && wr_ok[b] &&
            wr_addr[a*IDX_W +: IDX_W] == wr_addr[b*IDX_W +: IDX_W])
          conflict_d = 1'b1;
      end
    end
  end

  // Sets are applied after clears: a new producer outranks a writeback.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) busy_d[wr_addr[w*IDX_W +: IDX_W]] = 1'b0;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (busy_set_en[k]) busy_d[busy_set_addr[k*IDX_W +: IDX_W]] = 1'b1;
    end
    if (HAS_ZERO != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      busy_q      <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w])
          mem_q[wr_addr[w*IDX_W +: IDX_W]] <= wr_data[w*DATA_W +: DATA_W];
      end
      busy_q      <= busy_d;
      wr_conflict <= conflict_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [IDX_W-1:0] a;
    assign a = rd_addr[p*IDX_W +: IDX_W];
    regfile_read_port_m #(
      .DATA_W  (DATA_W),
      .IDX_W   (IDX_W),
      .NUM_WR  (NUM_WR),
      .HAS_ZERO(HAS_ZERO)
    ) u_rd (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en[p]),
      .rd_addr (a),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .mem_data(mem_q[a]),
      .mem_busy(busy_q[a]),
      .rd_data (rd_data[p*DATA_W +: DATA_W]),
      .rd_busy (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp_m.sv
// Directed and randomized checks of regfile_mp_m against an array-based model.
module tb_regfile_mp_m;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int IW = 5;
  localparam int NRD = 4;
  localparam int NWR = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD-1:0]    rd_en;
  logic [NRD*IW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*IW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NWR-1:0]    busy_set_en;
  logic [NWR*IW-1:0] busy_set_addr;
  logic              wr_conflict;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [NR];
  logic          m_busy[NR];
  logic [DW-1:0] e_data[NRD];
  logic          e_busy[NRD];
  logic          e_conf;

  regfile_mp_m dut (
    .clk          (clk),
    .reset        (reset),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_busy      (rd_busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy_set_en  (busy_set_en),
    .busy_set_addr(busy_set_addr),
    .wr_conflict  (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0;
    wr_data = '0; busy_set_en = '0; busy_set_addr = '0;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1; rd_addr[p*IW +: IW] = IW'(a);
  endtask

  task automatic wr(input int w, input int a, input logic [DW-1:0] d);
    wr_en[w] = 1'b1; wr_addr[w*IW +: IW] = IW'(a); wr_data[w*DW +: DW] = d;
  endtask

  task automatic bset(input int k, input int a);
    busy_set_en[k] = 1'b1; busy_set_addr[k*IW +: IW] = IW'(a);
  endtask

  // Model: evaluate reads/conflict on pre-edge state, then commit.
  task automatic tick();
    int cnt[NR];
    if (reset) begin
      for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
      for (int p = 0; p < NRD; p++) begin e_data[p] = '0; e_busy[p] = 0; end
      e_conf = 0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        if (rd_en[p]) begin
          int a = int'(rd_addr[p*IW +: IW]);
          if (a == 0) begin
            e_data[p] = '0; e_busy[p] = 0;
          end else begin
            e_data[p] = m_mem[a]; e_busy[p] = m_busy[a];
            for (int w = 0; w < NWR; w++)
              if (wr_en[w] && int'(wr_addr[w*IW +: IW]) == a) begin
                e_data[p] = wr_data[w*DW +: DW]; e_busy[p] = 0;
              end
          end
        end
      end
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      for (int w = 0; w < NWR; w++)
        if (wr_en[w]) cnt[int'(wr_addr[w*IW +: IW])]++;
      e_conf = 0;
      for (int i = 1; i < NR; i++) if (cnt[i] > 1) e_conf = 1;
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w*IW +: IW] != 0)
          m_mem[int'(wr_addr[w*IW +: IW])] = wr_data[w*DW +: DW];
      for (int w = 0; w < NWR; w++)
        if (wr_en[w]) m_busy[int'(wr_addr[w*IW +: IW])] = 0;
      for (int k = 0; k < NWR; k++)
        if (busy_set_en[k]) m_busy[int'(busy_set_addr[k*IW +: IW])] = 1;
      m_busy[0] = 0;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("rd_data[%0d]", p), rd_data[p*DW +: DW], e_data[p]);
      chk($sformatf("rd_busy[%0d]", p), DW'(rd_busy[p]), DW'(e_busy[p]));
    end
    chk("wr_conflict", DW'(wr_conflict), DW'(e_conf));
  endtask

  initial begin
    idle(); reset = 1; tick();
    for (int p = 0; p < NRD; p++) chk("reset_data", rd_data[p*DW +: DW], '0);
    chk("reset_conf", DW'(wr_conflict), '0);

    for (int r = 0; r < NR; r += NRD) begin
      idle();
      for (int p = 0; p < NRD; p++) rd(p, r + p);
      tick();
      for (int p = 0; p < NRD; p++) begin
        chk("init_zero", rd_data[p*DW +: DW], '0);
        chk("init_busy", DW'(rd_busy[p]), '0);
      end
    end

    idle(); wr(0, 5, 32'hDEADBEEF); rd(2, 5); tick();
    chk("x5_bypass", rd_data[2*DW +: DW], 32'hDEADBEEF);
    idle(); rd(1, 5); tick();
    chk("x5_array", rd_data[1*DW +: DW], 32'hDEADBEEF);

    idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7); tick();
    chk("x7_bypass", rd_data[0 +: DW], 32'h22);
    chk("x7_conf", DW'(wr_conflict), 32'd1);
    idle(); rd(0, 7); tick();
    chk("x7_conf_clr", DW'(wr_conflict), '0);
    chk("x7_array", rd_data[0 +: DW], 32'h22);

    idle(); wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'h1); bset(0, 0); tick();
    idle(); rd(3, 0); tick();
    chk("x0_data", rd_data[3*DW +: DW], '0);
    chk("x0_busy", DW'(rd_busy[3]), '0);
    chk("x0_conf", DW'(wr_conflict), '0);

    idle(); bset(1, 3); tick();
    idle(); rd(0, 3); tick();
    chk("x3_set", DW'(rd_busy[0]), 32'd1);
    idle(); wr(1, 3, 32'd9); bset(0, 3); rd(0, 3); tick();
    chk("x3_wb_data", rd_data[0 +: DW], 32'd9);
    chk("x3_wb_busy", DW'(rd_busy[0]), '0);
    idle(); rd(0, 3); tick();
    chk("x3_reset_wins", DW'(rd_busy[0]), 32'd1);
    idle(); wr(0, 3, 32'd10); tick();
    idle(); rd(0, 3); tick();
    chk("x3_cleared", DW'(rd_busy[0]), '0);

    idle(); bset(0, 1); bset(1, 2); wr(0, 4, 32'h44); tick();
    idle(); bset(0, 3); bset(1, 4); tick();
    idle(); reset = 1; tick();
    idle(); for (int p = 0; p < NRD; p++) rd(p, p + 1); tick();
    for (int p = 0; p < NRD; p++) begin
      chk("rst_busy", DW'(rd_busy[p]), '0);
      chk("rst_data", rd_data[p*DW +: DW], '0);
    end

    for (int n = 0; n < 400; n++) begin
      idle();
      rd_en = NRD'($urandom);
      wr_en = NWR'($urandom);
      busy_set_en = NWR'($urandom);
      for (int p = 0; p < NRD; p++)
        rd_addr[p*IW +: IW] = IW'($urandom_range(0, (n % 3 == 0) ? 31 : 7));
      for (int w = 0; w < NWR; w++) begin
        wr_addr[w*IW +: IW] = IW'($urandom_range(0, 7));
        wr_data[w*DW +: DW] = $urandom;
        busy_set_addr[w*IW +: IW] = IW'($urandom_range(0, 7));
      end
      reset = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
